// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encodings and nibble width for the sequential adder
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int NIB_W = 4;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - 4-bit carry-lookahead nibble adder exposing c3 and carry-out
module cla4_slice
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_ci,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_c3,
    output logic             o_co
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic             w_c1;
    logic             w_c2;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // o_c3 is the carry into bit 3; with o_co it yields signed overflow.
    assign w_c1 = w_g[0] | (w_p[0] & i_ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign o_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign o_co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_sum = w_p ^ {o_c3, w_c2, w_c1, i_ci};

endmodule

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - nibble-serial add/subtract sequencer with start/busy/done handshake
module cla_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_co;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_sum;
    logic             w_c3;
    logic             w_co;

    assign w_a_nib = r_a[{r_cnt, 2'b00} +: NIB_W];
    assign w_b_nib = r_b[{r_cnt, 2'b00} +: NIB_W];
    assign w_last  = (r_cnt == CNT_W'(NIB - 1));

    cla4_slice u_slice (
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_ci  (r_carry),
        .o_sum (w_sum),
        .o_c3  (w_c3),
        .o_co  (w_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub | ci;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            r_s[{r_cnt, 2'b00} +: NIB_W] <= w_sum;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_co  <= w_co;
                r_ovf <= w_c3 ^ w_co;
            end
        end
    end

    assign s   = r_s;
    assign co  = r_co;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - directed vector bench for the nibble-serial adder sequencer
module tb_cla_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    int n_total  = 0;
    int n_passed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] exp_s;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op_sub  (op_sub),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // Accept at the next posedge, then count busy cycles until done or timeout.
    task automatic launch(input logic [31:0] va, input logic [31:0] vb,
                          input logic vci, input logic vsub);
        @(negedge clk);
        start  = 1'b1;
        a      = va;
        b      = vb;
        ci     = vci;
        op_sub = vsub;
    endtask

    task automatic wait_done(output int n_busy);
        n_busy = 0;
        while (busy && n_busy < 20) begin
            n_busy++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        logic [31:0] held;
        launch(v.a, v.b, v.ci, v.sub);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ci    = 1'($urandom);
        wait_done(nb);
        chk($sformatf("v%0d_latency", idx), 64'(nb), 64'(NIB));
        chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_s", idx), 64'(s), 64'(v.exp_s));
        chk($sformatf("v%0d_co", idx), 64'(co), 64'(v.exp_co));
        chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.exp_ovf));
        held = s;
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_idle_done", idx), 64'({busy, done}), 64'd0);
        chk($sformatf("v%0d_s_held", idx), 64'(s), 64'(v.exp_s));
    endtask

    initial begin
        int nb;
        int n_done;
        int n_bsy;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
        #12;
        chk("reset_outputs", 64'({busy, done, co, ovf}), 64'd0);
        chk("reset_s", 64'(s), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_no_start", 64'({busy, done}), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // start held high through BUSY; drop it in the DONE cycle
        launch(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        @(negedge clk);
        n_done = 0;
        n_bsy  = 0;
        for (int k = 0; k < 14; k++) begin
            if (busy) n_bsy++;
            if (done) begin
                n_done++;
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_start_busy", 64'(n_bsy), 64'(NIB));
        chk("hold_start_dones", 64'(n_done), 64'd1);
        chk("hold_start_s", 64'(s), 64'h7);

        // back-to-back: re-start in the DONE cycle
        launch(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        chk("b2b_first_done", 64'(done), 64'd1);
        chk("b2b_first_s", 64'(s), 64'h2345_678A);
        start = 1'b1;
        a     = 32'h0000_000F;
        b     = 32'h0000_0001;
        ci    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_next", 64'({busy, done}), 64'b10);
        wait_done(nb);
        chk("b2b_latency", 64'(nb), 64'(NIB));
        chk("b2b_second_done", 64'(done), 64'd1);
        chk("b2b_second_s", 64'(s), 64'h0000_0010);
        @(negedge clk);

        // asynchronous reset in the third busy cycle
        launch(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_flags", 64'({busy, done, co, ovf}), 64'd0);
        chk("rst_async_s", 64'(s), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_stay_idle", 64'({busy, done}), 64'd0);
        run_vec(9, vecs[1]);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
